// File: rtl/apu_pkg.sv
// Shared definitions for the sound event scheduler: voice bit positions,
// scheduler state encoding and the fixed-priority grant encoder.
package apu_pkg;

    // Bit positions of the three APU voices in every 3-bit voice vector.
    localparam int VOICE_SAW    = 0;
    localparam int VOICE_SQUARE = 1;
    localparam int VOICE_NOISE  = 2;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Fixed priority noise > square > saw; returns a one-hot grant or zero.
    function automatic logic [2:0] prio_encode(input logic [2:0] set);
        logic [2:0] grant;
        grant = 3'b000;
        if (set[VOICE_NOISE]) begin
            grant[VOICE_NOISE] = 1'b1;
        end else if (set[VOICE_SQUARE]) begin
            grant[VOICE_SQUARE] = 1'b1;
        end else if (set[VOICE_SAW]) begin
            grant[VOICE_SAW] = 1'b1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: produces a registered one-cycle pulse on the first
// cycle the raster sits at the origin (x==0, y==0) after being elsewhere.
module frame_tick_gen (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic       frame_tick_o
);

    logic at_origin;
    logic at_origin_q;
    logic tick_q;

    assign at_origin = (x_i == 10'd0) && (y_i == 10'd0);

    // Remember last cycle's origin flag and register the rising edge of it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            at_origin_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            tick_q      <= at_origin & ~at_origin_q;
        end
    end

    assign frame_tick_o = tick_q;

endmodule

// File: rtl/sound_event_scheduler.sv
// Sound event scheduler: latches collision requests, arbitrates them by
// fixed priority and plays one APU voice at a time for a frame-counted
// duration, followed by an optional silent gap. Also provides the per-event
// envelope frame counter the APU uses instead of its free-running counter.
module sound_event_scheduler
    import apu_pkg::*;
#(
    parameter int SAW_FRAMES    = 32,
    parameter int SQUARE_FRAMES = 32,
    parameter int NOISE_FRAMES  = 16,
    parameter int GAP_FRAMES    = 2,
    parameter int DUR_BITS      = 6,
    parameter int PREEMPT       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SheepDragonCollision,
    input  logic       SwordDragonCollision,
    input  logic       PlayerDragonCollision,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       mute,
    output logic [2:0] voice_en,
    output logic [4:0] env_frame,
    output logic [2:0] pending,
    output logic       busy
);

    localparam logic [DUR_BITS-1:0] SAW_LD    = DUR_BITS'(SAW_FRAMES);
    localparam logic [DUR_BITS-1:0] SQUARE_LD = DUR_BITS'(SQUARE_FRAMES);
    localparam logic [DUR_BITS-1:0] NOISE_LD  = DUR_BITS'(NOISE_FRAMES);
    localparam logic [DUR_BITS-1:0] GAP_LD    = DUR_BITS'(GAP_FRAMES);
    localparam logic [DUR_BITS-1:0] CNT_ONE   = DUR_BITS'(1);
    localparam logic [4:0]          ENV_MAX   = 5'd31;

    // Duration reload for a one-hot voice vector.
    function automatic logic [DUR_BITS-1:0] frames_for(input logic [2:0] voice);
        logic [DUR_BITS-1:0] ld;
        ld = '0;
        if (voice[VOICE_NOISE]) begin
            ld = NOISE_LD;
        end else if (voice[VOICE_SQUARE]) begin
            ld = SQUARE_LD;
        end else if (voice[VOICE_SAW]) begin
            ld = SAW_LD;
        end
        return ld;
    endfunction

    // Envelope frame counter step, held at its maximum instead of wrapping.
    function automatic logic [4:0] env_step(input logic [4:0] env);
        return (env == ENV_MAX) ? ENV_MAX : env + 5'd1;
    endfunction

    logic                frame_tick;
    logic [2:0]          req;
    logic [2:0]          arb_set;
    logic [2:0]          top_grant;
    logic                higher_waiting;
    logic                retrig_hit;
    logic [2:0]          grant;
    logic [2:0]          retrig_mask;

    state_t              state_q, state_d;
    logic [2:0]          voice_q, voice_d;
    logic [2:0]          pending_q, pending_d;
    logic [DUR_BITS-1:0] dur_q, dur_d;
    logic [DUR_BITS-1:0] gap_q, gap_d;
    logic [4:0]          env_q, env_d;
    logic                busy_q;

    frame_tick_gen u_tick (
        .clk_i        (clk),
        .reset_i      (reset),
        .x_i          (x),
        .y_i          (y),
        .frame_tick_o (frame_tick)
    );

    assign req[VOICE_SAW]    = SheepDragonCollision;
    assign req[VOICE_SQUARE] = SwordDragonCollision;
    assign req[VOICE_NOISE]  = PlayerDragonCollision;

    // Same-cycle requests take part in arbitration alongside latched ones.
    assign arb_set        = pending_q | req;
    assign top_grant      = prio_encode(arb_set);
    // One-hot vectors order numerically the same way as voice priority.
    assign higher_waiting = (top_grant > voice_q);
    assign retrig_hit     = |(req & voice_q);

    // Next-state logic: grant, expiry, preempt, retrigger and gap counting.
    always_comb begin
        state_d     = state_q;
        voice_d     = voice_q;
        dur_d       = dur_q;
        gap_d       = gap_q;
        env_d       = env_q;
        grant       = 3'b000;
        retrig_mask = 3'b000;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick && (arb_set != 3'b000)) begin
                    grant   = top_grant;
                    voice_d = top_grant;
                    dur_d   = frames_for(top_grant);
                    env_d   = 5'd0;
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (frame_tick && (dur_q == CNT_ONE)) begin
                    // Expiry wins over preempt and retrigger on the same tick.
                    env_d   = env_step(env_q);
                    dur_d   = '0;
                    voice_d = 3'b000;
                    if (GAP_FRAMES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LD;
                    end
                end else if (frame_tick && (PREEMPT != 0) && higher_waiting) begin
                    // Switch straight to the higher voice; the old event is dropped.
                    grant   = top_grant;
                    voice_d = top_grant;
                    dur_d   = frames_for(top_grant);
                    env_d   = 5'd0;
                end else if (retrig_hit) begin
                    retrig_mask = voice_q;
                    dur_d       = frames_for(voice_q);
                    env_d       = 5'd0;
                end else if (frame_tick) begin
                    if (dur_q != '0) begin
                        dur_d = dur_q - CNT_ONE;
                    end
                    env_d = env_step(env_q);
                end
            end

            ST_GAP: begin
                if (frame_tick) begin
                    if (gap_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                    if (gap_q != '0) begin
                        gap_d = gap_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                voice_d = 3'b000;
            end
        endcase

        pending_d = arb_set & ~grant & ~retrig_mask;
    end

    // State and counter registers; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            voice_q   <= 3'b000;
            pending_q <= 3'b000;
            dur_q     <= '0;
            gap_q     <= '0;
            env_q     <= 5'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            voice_q   <= voice_d;
            pending_q <= pending_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            env_q     <= env_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Mute only gates the enables; sequencing carries on underneath.
    assign voice_en  = mute ? 3'b000 : voice_q;
    assign env_frame = env_q;
    assign pending   = pending_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Testbench for sound_event_scheduler: three instances (default, no preempt,
// no gap) share one stimulus stream; a reference model predicts every cycle's
// outputs into a scoreboard queue that an independent monitor drains.
module tb_sound_event_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       sheep, sword, player;
    logic [9:0] x, y;
    logic       mute;

    logic [2:0] voice_en_w  [3];
    logic [4:0] env_frame_w [3];
    logic [2:0] pending_w   [3];
    logic       busy_w      [3];

    always #5 clk = ~clk;

    sound_event_scheduler dut_a (
        .clk(clk), .reset(reset), .SheepDragonCollision(sheep),
        .SwordDragonCollision(sword), .PlayerDragonCollision(player),
        .x(x), .y(y), .mute(mute), .voice_en(voice_en_w[0]),
        .env_frame(env_frame_w[0]), .pending(pending_w[0]), .busy(busy_w[0])
    );

    sound_event_scheduler #(.PREEMPT(0)) dut_b (
        .clk(clk), .reset(reset), .SheepDragonCollision(sheep),
        .SwordDragonCollision(sword), .PlayerDragonCollision(player),
        .x(x), .y(y), .mute(mute), .voice_en(voice_en_w[1]),
        .env_frame(env_frame_w[1]), .pending(pending_w[1]), .busy(busy_w[1])
    );

    sound_event_scheduler #(.GAP_FRAMES(0)) dut_c (
        .clk(clk), .reset(reset), .SheepDragonCollision(sheep),
        .SwordDragonCollision(sword), .PlayerDragonCollision(player),
        .x(x), .y(y), .mute(mute), .voice_en(voice_en_w[2]),
        .env_frame(env_frame_w[2]), .pending(pending_w[2]), .busy(busy_w[2])
    );

    // Reference model state: st 0=idle 1=play 2=gap, voice -1 when silent.
    typedef struct {
        int       st;
        int       voice;
        int       dur;
        int       gap;
        int       env;
        bit [2:0] pend;
        bit       prev0;
        bit       tick;
    } mst_t;

    typedef struct packed {
        logic [2:0] ve;
        logic [4:0] ef;
        logic [2:0] pd;
        logic       bz;
    } exp_t;

    typedef exp_t [2:0] trio_t;

    mst_t  m [3];
    trio_t sbq [$];
    int    checks   = 0;
    int    failures = 0;
    int    pos      = 0;
    int    cyc      = 0;
    int    tick_count = 0;

    function automatic string inst_name(int k);
        return (k == 0) ? "dflt" : (k == 1) ? "nopre" : "nogap";
    endfunction

    function automatic int frames_of(int v);
        return (v == 2) ? 16 : 32;
    endfunction

    function automatic int gap_of(int k);
        return (k == 2) ? 0 : 2;
    endfunction

    function automatic bit preempt_of(int k);
        return (k != 1);
    endfunction

    function automatic mst_t mreset();
        mst_t s;
        s.st = 0; s.voice = -1; s.dur = 0; s.gap = 0; s.env = 0;
        s.pend = 3'b000; s.prev0 = 1'b0; s.tick = 1'b0;
        return s;
    endfunction

    // One clock of the scheduler rules as described behaviourally.
    function automatic mst_t mstep(mst_t s, logic [2:0] req, bit at0, bit rst, int k);
        mst_t     n;
        bit [2:0] set;
        int       hi;
        int       grant;
        bit       retrig;
        bit       t;
        if (rst) return mreset();
        n       = s;
        t       = s.tick;
        n.tick  = at0 && !s.prev0;
        n.prev0 = at0;
        set     = s.pend | req;
        hi      = -1;
        for (int i = 0; i < 3; i++) if (set[i]) hi = i;
        grant   = -1;
        retrig  = 1'b0;
        case (s.st)
            0: if (t && hi >= 0) begin
                grant = hi; n.st = 1; n.voice = hi; n.dur = frames_of(hi); n.env = 0;
            end
            1: begin
                if (t && s.dur == 1) begin
                    n.env = (s.env < 31) ? s.env + 1 : 31;
                    n.dur = 0; n.voice = -1;
                    if (gap_of(k) > 0) begin n.st = 2; n.gap = gap_of(k); end
                    else n.st = 0;
                end else if (t && preempt_of(k) && hi > s.voice) begin
                    grant = hi; n.voice = hi; n.dur = frames_of(hi); n.env = 0;
                end else if (req[s.voice]) begin
                    retrig = 1'b1; n.dur = frames_of(s.voice); n.env = 0;
                end else if (t) begin
                    if (s.dur > 0) n.dur = s.dur - 1;
                    n.env = (s.env < 31) ? s.env + 1 : 31;
                end
            end
            default: if (t) begin
                if (s.gap == 1) n.st = 0;
                if (s.gap > 0) n.gap = s.gap - 1;
            end
        endcase
        n.pend = set;
        if (grant >= 0) n.pend[grant] = 1'b0;
        if (retrig) n.pend[s.voice] = 1'b0;
        return n;
    endfunction

    function automatic exp_t mexp(mst_t s, bit mu);
        exp_t e;
        e.ve = (s.voice >= 0 && !mu) ? 3'(1 << s.voice) : 3'b000;
        e.ef = 5'(s.env);
        e.pd = s.pend;
        e.bz = (s.st != 0);
        return e;
    endfunction

    // Apply one cycle of stimulus; predict the outputs that will be seen
    // this cycle and advance the model past the coming edge.
    task automatic drive(input logic [2:0] req, input bit mu, input bit rst, input bit hold0);
        trio_t e;
        bit    at0;
        if (hold0) begin
            x = 10'd0; y = 10'd0;
        end else begin
            x = 10'(pos % 4); y = 10'(pos / 4); pos = (pos + 1) % 8;
        end
        at0    = (x == 10'd0) && (y == 10'd0);
        sheep  = req[0]; sword = req[1]; player = req[2];
        mute   = mu;
        reset  = rst;
        for (int k = 0; k < 3; k++) e[k] = mexp(m[k], mu);
        sbq.push_back(e);
        for (int k = 0; k < 3; k++) m[k] = mstep(m[k], req, at0, rst, k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic spot(input string nm, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Scoreboard monitor: compare every instance on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                trio_t e;
                exp_t  g;
                e = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    g.ve = voice_en_w[k]; g.ef = env_frame_w[k];
                    g.pd = pending_w[k];  g.bz = busy_w[k];
                    checks++;
                    if (g !== e[k]) begin
                        failures++;
                        $display("FAIL sb_%0s cyc=%0d got ve=%b ef=%0d pd=%b bz=%b want ve=%b ef=%0d pd=%b bz=%b",
                                 inst_name(k), cyc, g.ve, g.ef, g.pd, g.bz,
                                 e[k].ve, e[k].ef, e[k].pd, e[k].bz);
                    end
                end
                cyc++;
            end
        end
    end

    always @(negedge clk) if (dut_a.frame_tick) tick_count++;

    initial begin
        int c0;
        bit mu_r;
        bit hold_r;
        int hold_left;
        logic [2:0] rq;

        reset = 1'b1; sheep = 1'b0; sword = 1'b0; player = 1'b0;
        mute = 1'b0; x = 10'd5; y = 10'd5;
        for (int k = 0; k < 3; k++) m[k] = mreset();
        @(posedge clk);
        #1;

        // Single saw event: latch, grant one cycle after the tick, gap, idle.
        pos = 1;
        idle(2);
        pos = 3;
        drive(3'b001, 1'b0, 1'b0, 1'b0);
        spot("pend_after_pulse", {9'd0, pending_w[0]}, 12'h001);
        idle(5);
        spot("ven_before_grant", {9'd0, voice_en_w[0]}, 12'h000);
        idle(1);
        spot("ven_after_tick", {9'd0, voice_en_w[0]}, 12'h001);
        idle(300);
        spot("busy_cleared", {11'd0, busy_w[0]}, 12'h000);

        // Saw and noise together: noise first, then saw after the gap.
        drive(3'b101, 1'b0, 1'b0, 1'b0);
        idle(460);

        // Preempt of a playing saw by noise (no preempt on dut_b).
        drive(3'b001, 1'b0, 1'b0, 1'b0);
        idle(95);
        drive(3'b100, 1'b0, 1'b0, 1'b0);
        idle(600);

        // Square retrigger mid-event.
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        idle(170);
        drive(3'b010, 1'b0, 1'b0, 1'b0);
        idle(320);

        // Muted noise event: enables stay off while the envelope runs.
        drive(3'b100, 1'b1, 1'b0, 1'b0);
        repeat (180) drive(3'b000, 1'b1, 1'b0, 1'b0);
        spot("mute_ven", {9'd0, voice_en_w[0]}, 12'h000);
        idle(40);

        // Reset in the middle of play silences everything on the next edge.
        drive(3'b001, 1'b0, 1'b0, 1'b0);
        idle(40);
        drive(3'b000, 1'b0, 1'b1, 1'b0);
        spot("rst_midplay", {voice_en_w[0], env_frame_w[0], pending_w[0], busy_w[0]}, 12'h000);
        idle(3);

        // Raster held at the origin for five cycles yields one tick.
        pos = 1;
        idle(2);
        c0 = tick_count;
        repeat (5) drive(3'b000, 1'b0, 1'b0, 1'b1);
        pos = 3;
        idle(2);
        spot("hold_one_tick", 12'(tick_count - c0), 12'd1);

        // Randomised traffic: sparse requests, mute, origin holds, rare resets.
        hold_left = 0;
        for (int i = 0; i < 4000; i++) begin
            rq[0]  = ($urandom_range(0, 99) < 3);
            rq[1]  = ($urandom_range(0, 99) < 2);
            rq[2]  = ($urandom_range(0, 99) < 2);
            mu_r   = ($urandom_range(0, 9) == 0);
            if (hold_left == 0 && $urandom_range(0, 199) == 0) hold_left = $urandom_range(1, 5);
            hold_r = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            drive(rq, mu_r, ($urandom_range(0, 1499) == 0), hold_r);
        end
        idle(4);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d want=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
